// File: rtl/modbus_hreg_arbiter_pkg.sv
// Shared definitions for the Modbus holding-register bank and write arbiter:
// FSM state encoding, requester IDs and completion status codes.
package modbus_hreg_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // Requester IDs (also the encoding of the last-grant bit)
    localparam logic REQ_MB   = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    // Completion status
    localparam logic ST_OK  = 1'b0;
    localparam logic ST_REJ = 1'b1;

    // Full 8-bit compare against the bank size; no truncation or wrap.
    function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/modbus_hreg_arbiter_stretch.sv
// hreg_update_stretch: single-register update pulse stretcher. A trigger
// (re)loads the counter with INTR_CLOCK; the pulse is high while it is nonzero,
// so the output stays high for exactly INTR_CLOCK cycles after the last trigger.
module hreg_update_stretch #(
    parameter int INTR_CLOCK = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_trig,
    output logic o_pulse
);

    localparam int CW = $clog2(INTR_CLOCK + 1);

    logic [CW-1:0] r_cnt;

    // Restartable down-counter: trigger reloads, otherwise count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_trig)
            r_cnt <= CW'(INTR_CLOCK);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_pulse = (r_cnt != '0);

endmodule

// File: rtl/modbus_hreg_arbiter.sv
// modbus_hreg_arbiter: holding-register bank shared by the Modbus function
// handler (single-cycle write strobes) and the host interface (req/ack).
// Writes are serialised through an IDLE -> WRITE -> RESP FSM with round-robin
// tie-break; successful Modbus commits raise a stretched per-register update.
// Optional feature macro: HREG_WRITE_PROTECT_EN (adds wp_mask, Modbus only).
module modbus_hreg_arbiter
    import modbus_hreg_arbiter_pkg::*;
#(
    parameter int          NUM_REGS   = 4,
    parameter int          INTR_CLOCK = 5,
    parameter logic [15:0] RESET_VAL  = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef HREG_WRITE_PROTECT_EN
    input  logic [NUM_REGS-1:0]      wp_mask,
`endif
    input  logic                     mb_wen,
    input  logic [7:0]               mb_waddr,
    input  logic [15:0]              mb_wdat,
    output logic                     mb_w_done,
    output logic                     mb_w_status,
    output logic                     mb_overrun,
    input  logic                     host_req,
    input  logic [7:0]               host_addr,
    input  logic [15:0]              host_wdat,
    output logic                     host_ack,
    output logic                     host_err,
    output logic [16*NUM_REGS-1:0]   hreg_o,
    output logic [NUM_REGS-1:0]      update_o,
    output logic                     irq_o
);

    state_t                     r_state, w_state_nxt;
    logic                       r_mb_pend, r_mb_ovr;
    logic [7:0]                 r_mb_addr;
    logic [15:0]                r_mb_dat;
    logic                       r_host_pend;
    logic                       r_last, r_gnt, r_status;
    logic [7:0]                 r_wr_addr;
    logic [15:0]                r_wr_dat;
    logic [NUM_REGS-1:0][15:0]  r_hreg;

    logic                       w_grant, w_gnt_sel;
    logic                       w_mb_done, w_host_ack;
    logic                       w_prot, w_wr_ok;
    logic                       w_host_busy;
    logic [NUM_REGS-1:0]        w_upd_trig;

`ifdef HREG_WRITE_PROTECT_EN
    // Protection applies to Modbus writes only; the host may always write
    always_comb begin
        w_prot = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r_wr_addr == 8'(i))
                w_prot = wp_mask[i] && (r_gnt == REQ_MB);
    end
`else
    assign w_prot = 1'b0;
`endif

    assign w_wr_ok = addr_in_range(r_wr_addr, NUM_REGS) && !w_prot;

    // Next-state, grant selection and completion pulses
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_sel   = r_gnt;
        w_mb_done   = 1'b0;
        w_host_ack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_mb_pend || r_host_pend) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_WRITE;
                    if (r_mb_pend && r_host_pend)
                        w_gnt_sel = (r_last == REQ_HOST) ? REQ_MB : REQ_HOST;
                    else
                        w_gnt_sel = r_mb_pend ? REQ_MB : REQ_HOST;
                end
            end
            S_WRITE: w_state_nxt = S_RESP;
            S_RESP: begin
                w_mb_done   = (r_gnt == REQ_MB);
                w_host_ack  = (r_gnt == REQ_HOST);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Modbus capture: one outstanding write; a strobe on the clearing edge is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mb_pend <= 1'b0;
            r_mb_ovr  <= 1'b0;
            r_mb_addr <= '0;
            r_mb_dat  <= '0;
        end else begin
            if (mb_wen && (!r_mb_pend || w_mb_done)) begin
                r_mb_pend <= 1'b1;
                r_mb_addr <= mb_waddr;
                r_mb_dat  <= mb_wdat;
            end else if (w_mb_done) begin
                r_mb_pend <= 1'b0;
            end
            if (mb_wen && r_mb_pend && !w_mb_done)
                r_mb_ovr <= 1'b1;
        end
    end

    // Host is "in service" from grant until back in IDLE; masking the still-high
    // request there keeps the completed request from being seen twice.
    assign w_host_busy = ((r_state != S_IDLE) && (r_gnt == REQ_HOST)) ||
                         (w_grant && (w_gnt_sel == REQ_HOST));

    // Host request sampling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_host_pend <= 1'b0;
        else        r_host_pend <= host_req && !w_host_busy;
    end

    // Grant latch, write status and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= REQ_MB;
            r_last    <= REQ_HOST;
            r_status  <= ST_OK;
            r_wr_addr <= '0;
            r_wr_dat  <= '0;
        end else begin
            if (w_grant) begin
                r_gnt     <= w_gnt_sel;
                r_wr_addr <= (w_gnt_sel == REQ_MB) ? r_mb_addr : host_addr;
                r_wr_dat  <= (w_gnt_sel == REQ_MB) ? r_mb_dat  : host_wdat;
            end
            if (r_state == S_WRITE)
                r_status <= w_wr_ok ? ST_OK : ST_REJ;
            if (r_state == S_RESP)
                r_last <= r_gnt;
        end
    end

    // Register bank commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hreg <= {NUM_REGS{RESET_VAL}};
        end else if ((r_state == S_WRITE) && w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (r_wr_addr == 8'(i))
                    r_hreg[i] <= r_wr_dat;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_upd
        assign w_upd_trig[g] = w_mb_done && (r_status == ST_OK) && (r_wr_addr == 8'(g));
        hreg_update_stretch #(.INTR_CLOCK(INTR_CLOCK)) u_stretch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_trig  (w_upd_trig[g]),
            .o_pulse (update_o[g])
        );
    end

    assign mb_w_done   = w_mb_done;
    assign mb_w_status = w_mb_done && r_status;
    assign mb_overrun  = r_mb_ovr;
    assign host_ack    = w_host_ack;
    assign host_err    = w_host_ack && r_status;
    assign hreg_o      = r_hreg;
    assign irq_o       = |update_o;

endmodule

// File: tb/tb_modbus_hreg_arbiter.sv
// Self-checking bench for modbus_hreg_arbiter (NUM_REGS=4, INTR_CLOCK=5):
// directed vector table, hand-written multi-cycle sequences, and randomized
// writes checked against a transaction-level bank model.
module tb_modbus_hreg_arbiter;

    localparam int NR = 4;
    localparam int IC = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mb_wen = 1'b0;
    logic [7:0]         mb_waddr = '0;
    logic [15:0]        mb_wdat = '0;
    logic               mb_w_done, mb_w_status, mb_overrun;
    logic               host_req = 1'b0;
    logic [7:0]         host_addr = '0;
    logic [15:0]        host_wdat = '0;
    logic               host_ack, host_err;
    logic [16*NR-1:0]   hreg_o;
    logic [NR-1:0]      update_o;
    logic               irq_o;
`ifdef HREG_WRITE_PROTECT_EN
    logic [NR-1:0]      wp_mask = '0;
`endif

    modbus_hreg_arbiter #(.NUM_REGS(NR), .INTR_CLOCK(IC), .RESET_VAL(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef HREG_WRITE_PROTECT_EN
        .wp_mask     (wp_mask),
`endif
        .mb_wen      (mb_wen),
        .mb_waddr    (mb_waddr),
        .mb_wdat     (mb_wdat),
        .mb_w_done   (mb_w_done),
        .mb_w_status (mb_w_status),
        .mb_overrun  (mb_overrun),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_wdat   (host_wdat),
        .host_ack    (host_ack),
        .host_err    (host_err),
        .hreg_o      (hreg_o),
        .update_o    (update_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bank contents and who was served last (1 = host)
    logic [15:0] m_bank [NR];
    logic        m_last_host;

    typedef struct {
        logic        host;
        logic [7:0]  addr;
        logic [15:0] dat;
        logic        exp_st;
        logic [63:0] exp_bank;
    } vec_t;
    vec_t tab [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16*NR-1:0] m_packed();
        logic [16*NR-1:0] r;
        for (int i = 0; i < NR; i++) r[16*i +: 16] = m_bank[i];
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; mb_wen = 1'b0; host_req = 1'b0;
`ifdef HREG_WRITE_PROTECT_EN
        wp_mask = '0;
`endif
        repeat (2) step();
        chk("rst_hreg", 64'(hreg_o), 64'h0);
        chk("rst_outs", {mb_w_done, mb_w_status, mb_overrun, host_ack, host_err, update_o, irq_o}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) m_bank[i] = 16'h0000;
        m_last_host = 1'b1;
    endtask

    // Single Modbus write: done expected two cycles after the sampled strobe
    task automatic mb_write(input logic [7:0] a, input logic [15:0] d, output logic st);
        logic ok;
        logic [NR-1:0] u;
        int lat;
        mb_wen = 1'b1; mb_waddr = a; mb_wdat = d;
        step();
        mb_wen = 1'b0;
        ok = 1'b0; st = 1'b1; lat = 0;
        for (int i = 1; i <= 20 && !ok; i++) begin
            step();
            if (mb_w_done) begin ok = 1'b1; st = mb_w_status; lat = i; end
        end
        chk("mb_done_seen", ok, 1'b1);
        chk("mb_latency", lat, 2);
        m_last_host = 1'b0;
        step();
        if (ok && !st && a < NR) begin
            u = update_o >> a;
            chk("mb_update_set", u[0], 1'b1);
        end
    endtask

    // Single host write: ack expected two cycles after host_req is first sampled
    task automatic host_write(input logic [7:0] a, input logic [15:0] d, output logic e);
        logic ok;
        int lat;
        host_req = 1'b1; host_addr = a; host_wdat = d;
        ok = 1'b0; e = 1'b1; lat = 0;
        for (int i = 1; i <= 20 && !ok; i++) begin
            step();
            if (host_ack) begin ok = 1'b1; e = host_err; lat = i; end
        end
        chk("host_ack_seen", ok, 1'b1);
        chk("host_latency", lat, 3);
        m_last_host = 1'b1;
        step();
        host_req = 1'b0;
        step();
    endtask

    // Simultaneous Modbus strobe and host request
    task automatic both_write(input logic [7:0] ma, input logic [15:0] md,
                              input logic [7:0] ha, input logic [15:0] hd,
                              output logic mb_first, output int gap,
                              output logic mst, output logic hst);
        int tm, th;
        mb_wen = 1'b1; mb_waddr = ma; mb_wdat = md;
        host_req = 1'b1; host_addr = ha; host_wdat = hd;
        step();
        mb_wen = 1'b0;
        tm = -1; th = -1; mst = 1'b1; hst = 1'b1;
        for (int i = 0; i < 30 && (tm < 0 || th < 0); i++) begin
            step();
            if (th >= 0 && i == th + 1) host_req = 1'b0;
            if (mb_w_done) begin tm = i; mst = mb_w_status; end
            if (host_ack)  begin th = i; hst = host_err; end
        end
        if (host_req) begin step(); host_req = 1'b0; end
        step();
        chk("both_completed", (tm >= 0 && th >= 0), 1'b1);
        mb_first = (tm < th);
        gap = mb_first ? th - tm : tm - th;
        m_last_host = mb_first;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic st, st2, mbf;
        int gap, n, nd;
        logic flag;
        logic [7:0] a, ha;
        logic [15:0] d, hd;

        tab[0] = '{1'b0, 8'd1,   16'hA5A5, 1'b0, 64'h0000_0000_A5A5_0000};
        tab[1] = '{1'b0, 8'd4,   16'h1111, 1'b1, 64'h0000_0000_A5A5_0000};
        tab[2] = '{1'b1, 8'd200, 16'h2222, 1'b1, 64'h0000_0000_A5A5_0000};
        tab[3] = '{1'b1, 8'd3,   16'h0F0F, 1'b0, 64'h0F0F_0000_A5A5_0000};
        tab[4] = '{1'b0, 8'd0,   16'h00FF, 1'b0, 64'h0F0F_0000_A5A5_00FF};
        tab[5] = '{1'b1, 8'd4,   16'h3333, 1'b1, 64'h0F0F_0000_A5A5_00FF};
        tab[6] = '{1'b0, 8'd255, 16'h4444, 1'b1, 64'h0F0F_0000_A5A5_00FF};
        tab[7] = '{1'b1, 8'd2,   16'h1234, 1'b0, 64'h0F0F_1234_A5A5_00FF};
        tab[8] = '{1'b0, 8'd2,   16'h5678, 1'b0, 64'h0F0F_5678_A5A5_00FF};
        tab[9] = '{1'b1, 8'd1,   16'hBEEF, 1'b0, 64'h0F0F_5678_BEEF_00FF};

        // Directed vector table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (tab[i].host) host_write(tab[i].addr, tab[i].dat, st);
            else             mb_write(tab[i].addr, tab[i].dat, st);
            chk($sformatf("vec%0d_status", i), st, tab[i].exp_st);
            chk($sformatf("vec%0d_bank", i), 64'(hreg_o), tab[i].exp_bank);
        end

        // Update pulse width after a single Modbus write
        do_reset();
        mb_wen = 1'b1; mb_waddr = 8'd1; mb_wdat = 16'hA5A5;
        step();
        mb_wen = 1'b0;
        step();
        chk("A_no_early_done", mb_w_done, 1'b0);
        step();
        chk("A_done", mb_w_done, 1'b1);
        chk("A_status", mb_w_status, 1'b0);
        chk("A_reg1", hreg_o[31:16], 16'hA5A5);
        step();
        chk("A_update", update_o, 4'b0010);
        chk("A_irq", irq_o, 1'b1);
        n = 1;
        for (int i = 0; i < 20 && update_o[1]; i++) begin
            step();
            if (update_o[1]) n++;
        end
        chk("A_upd_width", n, IC);
        chk("A_irq_low", irq_o, 1'b0);

        // Contention right after reset: Modbus wins the first tie
        do_reset();
        both_write(8'd0, 16'h00FF, 8'd2, 16'h1234, mbf, gap, st, st2);
        chk("B_mb_first", mbf, 1'b1);
        chk("B_gap", gap, 3);
        chk("B_status", {st, st2}, 2'b00);
        chk("B_bank", 64'(hreg_o), 64'h0000_1234_0000_00FF);
        flag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (update_o[2]) flag = 1'b1;
            step();
        end
        chk("B_no_host_update", flag, 1'b0);

        // Overrun: second strobe while the first is pending
        do_reset();
        mb_wen = 1'b1; mb_waddr = 8'd3; mb_wdat = 16'h1111;
        step();
        mb_wdat = 16'h2222;
        step();
        mb_wen = 1'b0;
        chk("C_overrun_set", mb_overrun, 1'b1);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (mb_w_done) nd++;
            step();
        end
        chk("C_one_done", nd, 1);
        chk("C_reg3", hreg_o[63:48], 16'h1111);
        chk("C_overrun_sticky", mb_overrun, 1'b1);

        // Restart: strobes 3 cycles apart, second lands on the clearing edge
        do_reset();
        mb_wen = 1'b1; mb_waddr = 8'd3; mb_wdat = 16'h0001;
        step();
        mb_wen = 1'b0;
        step();
        step();
        mb_wen = 1'b1; mb_wdat = 16'h0002;
        step();
        mb_wen = 1'b0;
        chk("D_upd_on", update_o[3], 1'b1);
        n = 1;
        for (int i = 0; i < 30 && update_o[3]; i++) begin
            step();
            if (update_o[3]) n++;
        end
        chk("D_upd_len", n, 3 + IC);
        chk("D_no_overrun", mb_overrun, 1'b0);
        chk("D_reg3", hreg_o[63:48], 16'h0002);

        // Reset in the middle of a write aborts it
        do_reset();
        mb_wen = 1'b1; mb_waddr = 8'd1; mb_wdat = 16'hDEAD;
        step();
        mb_wen = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("E_outs_in_rst", {mb_w_done, host_ack, update_o, hreg_o}, 0);
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mb_w_done || host_ack) nd++;
        end
        chk("E_no_done", nd, 0);
        chk("E_bank", 64'(hreg_o), 64'h0);

`ifdef HREG_WRITE_PROTECT_EN
        // Write protection: Modbus rejected, host unaffected
        do_reset();
        wp_mask = 4'b0001;
        mb_write(8'd0, 16'h1111, st);
        chk("WP_mb_rej", st, 1'b1);
        chk("WP_reg0_kept", hreg_o[15:0], 16'h0000);
        chk("WP_no_update", update_o, 4'b0000);
        host_write(8'd0, 16'hBEEF, st);
        chk("WP_host_ok", st, 1'b0);
        chk("WP_reg0_host", hreg_o[15:0], 16'hBEEF);
        wp_mask = '0;
`endif

        // Randomized writes against the transaction model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            a  = ($urandom_range(0, 5) == 5) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            ha = ($urandom_range(0, 5) == 5) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            d  = 16'($urandom);
            hd = 16'($urandom);
            if (kind == 0) begin
                mb_write(a, d, st);
                chk("R_mb_status", st, (a >= NR));
                if (a < NR) m_bank[a] = d;
            end else if (kind == 1) begin
                host_write(ha, hd, st);
                chk("R_host_status", st, (ha >= NR));
                if (ha < NR) m_bank[ha] = hd;
            end else begin
                logic exp_mb_first;
                exp_mb_first = m_last_host;
                both_write(a, d, ha, hd, mbf, gap, st, st2);
                chk("R_order", mbf, exp_mb_first);
                chk("R_gap", gap, 3);
                chk("R_both_status", {st, st2}, {(a >= NR), (ha >= NR)});
                if (exp_mb_first) begin
                    if (a  < NR) m_bank[a]  = d;
                    if (ha < NR) m_bank[ha] = hd;
                end else begin
                    if (ha < NR) m_bank[ha] = hd;
                    if (a  < NR) m_bank[a]  = d;
                end
            end
            chk("R_bank", 64'(hreg_o), 64'(m_packed()));
        end
        chk("R_no_overrun", mb_overrun, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
